// File: rtl/mem_write_arbiter.sv
// mem_write_arbiter: shares the LPDDR MCB p4 write port between two
// single-word write requesters (0 = pixel writer, 1 = processor store path).
// Each grant becomes one data push to the MCB write FIFO followed by one
// write command.
//
// Ports:
//   clk, rst              system clock, synchronous active-high reset
//   enable                grants allowed only while high (calibration done)
//   req/addr/data/be 0,1  requests, held stable until the matching ack
//   ack0, ack1            one-cycle pulse when the command is issued
//   mem_cmd_*             MCB command port (write, burst length 1)
//   mem_wr_*              MCB write-data port and its status flags
//   busy                  high whenever a transaction is in progress
//   err                   sticky MCB write-port error, cleared by rst
module mem_write_arbiter #(
  parameter int unsigned FIXED_PRIORITY = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        req0,
  input  logic [29:0] addr0,
  input  logic [31:0] data0,
  input  logic [3:0]  be0,
  output logic        ack0,
  input  logic        req1,
  input  logic [29:0] addr1,
  input  logic [31:0] data1,
  input  logic [3:0]  be1,
  output logic        ack1,
  output logic        mem_cmd_en,
  output logic [2:0]  mem_cmd_instr,
  output logic [5:0]  mem_cmd_bl,
  output logic [29:0] mem_cmd_byte_addr,
  input  logic        mem_cmd_full,
  output logic        mem_wr_en,
  output logic [3:0]  mem_wr_mask,
  output logic [31:0] mem_wr_data,
  input  logic        mem_wr_full,
  input  logic        mem_wr_underrun,
  input  logic        mem_wr_error,
  output logic        busy,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, LOAD, ISSUE} state_t;

  state_t      state, state_nxt;
  logic        grant;
  logic        win;
  logic        last_grant;
  logic        grant_id;
  logic [29:0] addr_q;
  logic [31:0] data_q;
  logic [3:0]  mask_q;

  // Arbitration: a lone requester wins; on a tie either requester 0 always
  // wins or the one that was not granted last time does.
  always_comb begin
    grant = enable && !mem_wr_full && (req0 || req1);
    if (req0 && req1)
      win = (FIXED_PRIORITY != 0) ? 1'b0 : ~last_grant;
    else
      win = req1;
  end

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (grant) state_nxt = LOAD;
      LOAD:    state_nxt = ISSUE;
      ISSUE:   if (!mem_cmd_full) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_wr_en  = (state == LOAD);
    mem_cmd_en = (state == ISSUE) && !mem_cmd_full;
    ack0       = mem_cmd_en && !grant_id;
    ack1       = mem_cmd_en && grant_id;
    busy       = (state != IDLE);
  end

  // The mask is stored already inverted so that every latched output reads
  // zero straight after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
      grant_id   <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      mask_q     <= '0;
      err        <= 1'b0;
    end else begin
      err <= err | mem_wr_underrun | mem_wr_error;
      if (state == IDLE && grant) begin
        grant_id   <= win;
        last_grant <= win;
        addr_q     <= win ? addr1 : addr0;
        data_q     <= win ? data1 : data0;
        mask_q     <= ~(win ? be1 : be0);
      end
    end
  end

  assign mem_cmd_instr     = 3'b000;
  assign mem_cmd_bl        = 6'd0;
  assign mem_cmd_byte_addr = addr_q & {{28{1'b1}}, 2'b00};
  assign mem_wr_data       = data_q;
  assign mem_wr_mask       = mask_q;

endmodule

// File: tb/tb_mem_write_arbiter.sv
module tb_mem_write_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, enable;
  logic        req0, req1;
  logic [29:0] addr0, addr1;
  logic [31:0] data0, data1;
  logic [3:0]  be0, be1;
  logic        mem_cmd_full, mem_wr_full, mem_wr_underrun, mem_wr_error;

  logic        ack0, ack1, cmd_en, wr_en, busy, err;
  logic [2:0]  instr;
  logic [5:0]  bl;
  logic [29:0] byte_addr;
  logic [3:0]  wr_mask;
  logic [31:0] wr_data;

  logic        f_ack0, f_ack1, f_cmd_en, f_wr_en, f_busy, f_err;
  logic [2:0]  f_instr;
  logic [5:0]  f_bl;
  logic [29:0] f_byte_addr;
  logic [3:0]  f_wr_mask;
  logic [31:0] f_wr_data;

  mem_write_arbiter #(.FIXED_PRIORITY(0)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .req0(req0), .addr0(addr0), .data0(data0), .be0(be0), .ack0(ack0),
    .req1(req1), .addr1(addr1), .data1(data1), .be1(be1), .ack1(ack1),
    .mem_cmd_en(cmd_en), .mem_cmd_instr(instr), .mem_cmd_bl(bl),
    .mem_cmd_byte_addr(byte_addr), .mem_cmd_full(mem_cmd_full),
    .mem_wr_en(wr_en), .mem_wr_mask(wr_mask), .mem_wr_data(wr_data),
    .mem_wr_full(mem_wr_full), .mem_wr_underrun(mem_wr_underrun),
    .mem_wr_error(mem_wr_error), .busy(busy), .err(err)
  );

  mem_write_arbiter #(.FIXED_PRIORITY(1)) dut_fp (
    .clk(clk), .rst(rst), .enable(enable),
    .req0(req0), .addr0(addr0), .data0(data0), .be0(be0), .ack0(f_ack0),
    .req1(req1), .addr1(addr1), .data1(data1), .be1(be1), .ack1(f_ack1),
    .mem_cmd_en(f_cmd_en), .mem_cmd_instr(f_instr), .mem_cmd_bl(f_bl),
    .mem_cmd_byte_addr(f_byte_addr), .mem_cmd_full(mem_cmd_full),
    .mem_wr_en(f_wr_en), .mem_wr_mask(f_wr_mask), .mem_wr_data(f_wr_data),
    .mem_wr_full(mem_wr_full), .mem_wr_underrun(mem_wr_underrun),
    .mem_wr_error(mem_wr_error), .busy(f_busy), .err(f_err)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Transaction-level model of the rr instance: one outstanding write whose
  // data push happens the cycle after the grant and whose command goes out on
  // the first later cycle the command FIFO is not full.
  bit          chk_on = 1'b0;
  bit          m_act, m_pushed, m_last, m_id, m_err, w;
  logic [29:0] m_addr;
  logic [31:0] m_data;
  logic [3:0]  m_mask;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      chk_on = 1'b1;
      m_act = 0; m_pushed = 0; m_last = 1; m_id = 0; m_err = 0;
      m_addr = '0; m_data = '0; m_mask = '0;
    end else begin
      if (mem_wr_underrun || mem_wr_error) m_err = 1;
      if (!m_act) begin
        if (enable && !mem_wr_full && (req0 || req1)) begin
          w = (req0 && req1) ? !m_last : req1;
          m_id = w; m_last = w;
          m_addr = w ? addr1 : addr0;
          m_data = w ? data1 : data0;
          m_mask = ~(w ? be1 : be0);
          m_act = 1; m_pushed = 0;
        end
      end else if (!m_pushed) begin
        m_pushed = 1;
      end else if (!mem_cmd_full) begin
        m_act = 0;
      end
    end
  end

  bit e_cmd;
  always @(negedge clk) begin
    if (chk_on) begin
      e_cmd = m_act && m_pushed && !mem_cmd_full;
      chk("m_wr_en", wr_en, m_act && !m_pushed);
      chk("m_cmd_en", cmd_en, e_cmd);
      chk("m_ack0", ack0, e_cmd && !m_id);
      chk("m_ack1", ack1, e_cmd && m_id);
      chk("m_busy", busy, m_act);
      chk("m_addr", byte_addr, {m_addr[29:2], 2'b00});
      chk("m_data", wr_data, m_data);
      chk("m_mask", wr_mask, m_mask);
      chk("m_err", err, m_err);
      chk("m_instr", instr, 3'b000);
      chk("m_bl", bl, 6'd0);
    end
  end

  // Ack / strobe logging for the ordering and pulse-count checks.
  int ids[$], tms[$], fids[$];
  int f_ack1_cnt = 0;
  int wr_en_cnt = 0;
  always @(negedge clk) begin
    if (chk_on && !rst) begin
      if (ack0) begin ids.push_back(0); tms.push_back(cyc); end
      if (ack1) begin ids.push_back(1); tms.push_back(cyc); end
      if (f_ack0) fids.push_back(0);
      if (f_ack1) begin fids.push_back(1); f_ack1_cnt++; end
      if (wr_en) wr_en_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1; req0 = 0; req1 = 0;
    tick(); tick();
    rst = 0;
  endtask

  int rr_exp[4] = '{0, 1, 0, 1};
  int n;

  initial begin
    rst = 1; enable = 0; req0 = 0; req1 = 0;
    addr0 = '0; addr1 = '0; data0 = '0; data1 = '0; be0 = '0; be1 = '0;
    mem_cmd_full = 0; mem_wr_full = 0; mem_wr_underrun = 0; mem_wr_error = 0;
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_mask", wr_mask, 0);
    chk("rst_data", wr_data, 0);
    chk("rst_addr", byte_addr, 0);
    chk("rst_err", err, 0);
    chk("rst_strobes", {ack0, ack1, cmd_en, wr_en}, 0);
    rst = 0;

    // Single request
    enable = 1;
    req0 = 1; addr0 = 30'h0000_1237; data0 = 32'hA5A5_1234; be0 = 4'b0011;
    tick();
    chk("single_wr_en", wr_en, 1);
    chk("single_wr_data", wr_data, 32'hA5A5_1234);
    chk("single_wr_mask", wr_mask, 4'b1100);
    chk("single_cmd_early", cmd_en, 0);
    tick();
    chk("single_cmd_en", cmd_en, 1);
    chk("single_addr", byte_addr, 30'h0000_1234);
    chk("single_ack0", ack0, 1);
    req0 = 0;
    tick();
    chk("single_idle", busy, 0);

    // Contention, both instances
    do_reset();
    ids.delete(); tms.delete(); fids.delete(); f_ack1_cnt = 0;
    enable = 1;
    req0 = 1; addr0 = 30'h100; data0 = 32'h1111_1111; be0 = 4'hF;
    req1 = 1; addr1 = 30'h200; data1 = 32'h2222_2222; be1 = 4'h5;
    n = 0;
    for (int i = 0; i < 20 && n < 4; i++) begin
      tick();
      if (ack0 || ack1) n++;
    end
    req0 = 0; req1 = 0;
    chk("cont_ack_budget", n, 4);
    tick(); tick();
    chk("rr_count", ids.size(), 4);
    for (int i = 0; i < 4 && i < ids.size(); i++) chk("rr_order", ids[i], rr_exp[i]);
    for (int i = 1; i < 4 && i < tms.size(); i++) chk("rr_spacing", tms[i] - tms[i-1], 3);
    chk("fp_count", fids.size(), 4);
    for (int i = 0; i < fids.size(); i++) chk("fp_order", fids[i], 0);
    chk("fp_ack1_never", f_ack1_cnt, 0);

    // Write FIFO full backpressure
    do_reset();
    enable = 1; mem_wr_full = 1;
    req1 = 1; addr1 = 30'h2000_0ABE; data1 = 32'hDEAD_BEEF; be1 = 4'b1001;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("wrfull_no_wr_en", wr_en, 0);
      chk("wrfull_no_busy", busy, 0);
    end
    mem_wr_full = 0;
    tick();
    chk("wrfull_grant", wr_en, 1);
    chk("wrfull_mask", wr_mask, 4'b0110);
    chk("wrfull_data", wr_data, 32'hDEAD_BEEF);
    tick();
    chk("wrfull_ack1", ack1, 1);
    chk("wrfull_addr", byte_addr, 30'h2000_0ABC);
    req1 = 0;
    tick();

    // Command FIFO full for 4 ISSUE cycles
    wr_en_cnt = 0;
    req0 = 1; addr0 = 30'h44; data0 = 32'h0BAD_F00D; be0 = 4'hF;
    tick();
    chk("cmdfull_load", wr_en, 1);
    mem_cmd_full = 1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick(); else tick();
      chk("cmdfull_hold_cmd", cmd_en, 0);
      chk("cmdfull_hold_ack", ack0, 0);
      chk("cmdfull_hold_busy", busy, 1);
    end
    tick();
    mem_cmd_full = 0;
    #1;
    chk("cmdfull_cmd_en", cmd_en, 1);
    chk("cmdfull_ack0", ack0, 1);
    req0 = 0;
    tick();
    chk("cmdfull_one_push", wr_en_cnt, 1);

    // Enable gating
    enable = 0;
    req0 = 1; addr0 = 30'h3FFF_FFF0; data0 = 32'hCAFE_0001; be0 = 4'b0100;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("en_off_quiet", {busy, wr_en, cmd_en, ack0, ack1}, 0);
    end
    enable = 1;
    tick();
    chk("en_load", wr_en, 1);
    enable = 0;
    tick();
    chk("en_drop_ack0", ack0, 1);
    req0 = 0;
    tick();
    chk("en_back_idle", busy, 0);

    // Sticky error, then reset during ISSUE
    enable = 1;
    chk("err_clear", err, 0);
    mem_wr_error = 1;
    tick();
    mem_wr_error = 0;
    chk("err_set", err, 1);
    tick(); tick(); tick();
    chk("err_sticky", err, 1);
    req0 = 1; addr0 = 30'h80; data0 = 32'h5555_AAAA; be0 = 4'hF;
    tick();
    mem_cmd_full = 1;
    tick();
    chk("rstmid_issue", {busy, ack0}, 2'b10);
    rst = 1;
    tick();
    chk("rstmid_idle", busy, 0);
    chk("rstmid_no_ack", ack0, 0);
    chk("rstmid_err", err, 0);
    rst = 0; req0 = 0; mem_cmd_full = 0;
    tick(); tick();
    chk("rstmid_quiet", {busy, ack0, wr_en}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/mem_write_arbiter.md
# mem_write_arbiter

Shares one LPDDR MCB write port between two word-write requesters: requester 0 is the pixel writer and requester 1 is the processor data-store path. Each granted request becomes one single-word MCB write: a data push to the write FIFO, then a write command. The block sits between the requesters and the `c3_p4_*` port of `s6_lpddr_ram`. It uses round-robin or fixed priority and holds a sticky error flag for the port.

## Interface
Parameters:
- FIXED_PRIORITY, 0, 0 = round-robin between requesters; 1 = requester 0 always wins ties

Ports:
- clk  input  1  system clock (100 MHz); clocks the arbiter and the MCB p4 cmd/wr FIFOs
- rst  input  1  synchronous, active-high reset
- enable  input  1  grants allowed only when high (tie to memory calibration done)
- req0 / req1  input  1  write request; held high with stable addr/data/be until ack
- addr0 / addr1  input  30  byte address; bits [1:0] ignored
- data0 / data1  input  32  write word
- be0 / be1  input  4  byte enables, active-high, bit i covers data[8i+7:8i]
- ack0 / ack1  output  1  one-cycle pulse: the command has been issued to the MCB
- mem_cmd_en  output  1  MCB command strobe
- mem_cmd_instr  output  3  constant 3'b000 (write)
- mem_cmd_bl  output  6  constant 6'd0 (burst of 1 word)
- mem_cmd_byte_addr  output  30  {latched addr[29:2], 2'b00}
- mem_cmd_full  input  1  MCB command FIFO full
- mem_wr_en  output  1  MCB write-data strobe
- mem_wr_mask  output  4  ~latched be; MCB mask is active-high, meaning "do not write"
- mem_wr_data  output  32  latched data
- mem_wr_full  input  1  MCB write FIFO full
- mem_wr_underrun, mem_wr_error  input  1  MCB write-port error flags
- busy  output  1  high in any state other than IDLE
- err  output  1  sticky: set when mem_wr_underrun or mem_wr_error is high; cleared only by rst

## Operation
- States: IDLE, LOAD, ISSUE.
- IDLE: a grant occurs when enable=1, mem_wr_full=0 and (req0|req1).
  - Winner when only one requester is active: that requester.
  - Winner when both are active and FIXED_PRIORITY=0: the requester opposite last_grant.
  - Winner when both are active and FIXED_PRIORITY=1: requester 0.
  - On a grant: latch addr/data/be of the winner, set grant_id and last_grant, go to LOAD.
  - With no grant, stay in IDLE.
- LOAD: mem_wr_en=1 for exactly this one cycle, with mem_wr_data/mem_wr_mask driven from the latched registers. Go to ISSUE.
- ISSUE, mem_cmd_full=0: mem_cmd_en=1 and ack<grant_id>=1 in the same cycle, with mem_cmd_byte_addr from the latched address. Go to IDLE.
- ISSUE, mem_cmd_full=1: hold in ISSUE with mem_cmd_en=0 and no ack.
- enable and mem_wr_full are sampled only in IDLE. A transaction already in progress always completes.
- A requester that still holds req in the cycle after its ack is treated as a new request.
- mem_cmd_byte_addr, mem_wr_data and mem_wr_mask hold their last latched values outside LOAD/ISSUE.
- err sets on the cycle after the error input is seen and stays set until rst.

## Timing
- Reset (rst=1 at a clk edge):
  - Returns to IDLE; last_grant=1, so requester 0 wins the first tie.
  - Clears all latched registers and err.
  - All outputs read 0 except mem_cmd_instr=000 and mem_cmd_bl=0.
  - ack0/ack1, mem_cmd_en, mem_wr_en and busy are all 0.
- Reset mid-transaction: the transaction is abandoned and no ack is issued. Any data already pushed is the system's problem; reset accompanies MCB reset.
- Request sampled in IDLE at cycle N (idle arbiter, no full flags):
  - N+1: mem_wr_en=1.
  - N+2: mem_cmd_en=1 and ack=1.
  - N+3: back in IDLE and able to grant.
  - Peak throughput: one write per 3 cycles.
- Each cycle mem_cmd_full holds the block in ISSUE adds one cycle of latency.
- A grant is never made in a cycle where mem_wr_full=1.
- Data always precedes its command by at least one cycle.
- Strobes and acks are never asserted while enable=0 and the block is in IDLE.

## Test plan
- Single request: req0=1, addr0=0x0000_1237, data0=0xA5A5_1234, be0=4'b0011. Required:
  - Cycle +1: wr_en=1, wr_data=0xA5A51234, wr_mask=4'b1100.
  - Cycle +2: cmd_en=1, byte_addr=0x0000_1234, instr=0, bl=0, ack0=1.
- Contention: req0 and req1 held continuously for 4 transactions. Required:
  - FIXED_PRIORITY=0: grants in order 0,1,0,1; each ack arrives 3 cycles apart.
  - FIXED_PRIORITY=1: grants in order 0,0,0,0; ack1 is never asserted.
- Backpressure:
  - mem_wr_full=1 for 5 cycles with req1=1: no wr_en during those cycles; the grant comes on the first cycle after full drops.
  - mem_cmd_full=1 for 4 cycles while in ISSUE: cmd_en and ack are delayed exactly 4 cycles, and wr_en pulses exactly once.
- Enable gating: enable=0 with req0=1 gives no activity for 10 cycles. Dropping enable during LOAD still completes that write with ack0.
- Errors and reset: a one-cycle pulse on mem_wr_error sets err and it stays set. rst asserted during ISSUE gives IDLE next cycle, no ack, and err=0.
